// File: rtl/enemy_scheduler_pkg.sv
// enemy_scheduler_pkg: shared game scene encodings, lane geometry and spawn interval helper
package enemy_scheduler_pkg;
  typedef enum logic [1:0] {SCENE_TITLE, SCENE_PLAY, SCENE_OVER, SCENE_RSVD} scene_t;
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PICK, S_PENDING} state_t;
  localparam logic [1:0] SC_PLAY = SCENE_PLAY;
  localparam int N_LANES = 4;
  localparam int LANE_X0_DEF = 64;
  localparam int LANE_PITCH_DEF = 48;
  // Saturates at zero before applying the floor so high levels never wrap.
  function automatic logic [9:0] spawn_interval(input logic [4:0] level, input int base, input int step, input int min_iv);
    logic [9:0] sub;
    logic [9:0] diff;
    sub = 10'(int'(level) * step);
    diff = (10'(base) > sub) ? 10'(base) - sub : 10'd0;
    return (diff < 10'(min_iv)) ? 10'(min_iv) : diff;
  endfunction
endpackage

// File: rtl/enemy_scheduler_rr_pick.sv
// rr_pick: combinational round-robin first-free finder starting at ptr
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] grant,
  output logic         found
);
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!found && req[j] && j == (int'(ptr) + i) % N) begin
          grant[j] = 1'b1;
          found = 1'b1;
        end
  end
endmodule

// File: rtl/enemy_scheduler.sv
// enemy_scheduler: level-paced enemy spawner with round-robin slot allocation and LFSR lane choice
module enemy_scheduler
  import enemy_scheduler_pkg::*;
#(
  parameter int N_SLOTS       = 4,
  parameter int BASE_INTERVAL = 90,
  parameter int LEVEL_STEP    = 4,
  parameter int MIN_INTERVAL  = 20,
  parameter int LANE_X0       = LANE_X0_DEF,
  parameter int LANE_PITCH    = LANE_PITCH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [1:0]         scene,
  input  logic [4:0]         level,
  input  logic [N_SLOTS-1:0] slot_free,
  output logic [N_SLOTS-1:0] spawn,
  output logic [8:0]         spawn_X,
  output logic               spawned,
  output logic [3:0]         active_cnt
);
  state_t state;
  logic [7:0] tick_cnt;
  logic [2:0] rr_ptr;
  logic [2:0] nxt_ptr;
  logic [7:0] lfsr;
  logic [1:0] last_lane;
  logic [1:0] lane;
  logic [8:0] lane_x;
  logic [9:0] interval;
  logic tick_hit;
  logic [N_SLOTS-1:0] grant;
  logic found;
  rr_pick #(.N(N_SLOTS)) u_pick (
    .req  (slot_free),
    .ptr  (rr_ptr),
    .grant(grant),
    .found(found)
  );
  assign interval = spawn_interval(level, BASE_INTERVAL, LEVEL_STEP, MIN_INTERVAL);
  assign tick_hit = clk_en && ({2'b00, tick_cnt} + 10'd1 >= interval);
  // Never repeat the previous lane: bump a collision to the neighbouring lane.
  assign lane = (lfsr[1:0] == last_lane) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
  assign lane_x = 9'(LANE_X0 + int'(lane) * LANE_PITCH);
  always_comb begin
    nxt_ptr = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (grant[i]) nxt_ptr = 3'((i + 1) % N_SLOTS);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tick_cnt <= '0;
      rr_ptr <= '0;
      lfsr <= 8'hA5;
      last_lane <= '0;
      spawn <= '0;
      spawned <= 1'b0;
      spawn_X <= '0;
      active_cnt <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      spawn <= '0;
      spawned <= 1'b0;
      active_cnt <= 4'($countones(~slot_free));
      if (scene != SC_PLAY) begin
        state <= S_IDLE;
        tick_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            tick_cnt <= '0;
            state <= S_COUNT;
          end
          S_COUNT:
            if (clk_en) begin
              tick_cnt <= tick_hit ? 8'd0 : tick_cnt + 8'd1;
              state <= tick_hit ? S_PICK : S_COUNT;
            end
          default:
            if (found) begin
              spawn <= grant;
              spawned <= 1'b1;
              spawn_X <= lane_x;
              last_lane <= lane;
              rr_ptr <= nxt_ptr;
              state <= S_COUNT;
            end else state <= S_PENDING;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_enemy_scheduler.sv
// tb_enemy_scheduler: directed self-checking bench for enemy_scheduler
module tb_enemy_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic [1:0] scene = 2'd0;
  logic [4:0] level = 5'd0;
  logic [3:0] slot_free = 4'hF;
  logic [3:0] spawn;
  logic [8:0] spawn_X;
  logic       spawned;
  logic [3:0] active_cnt;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [1:0] m_last = 2'd0;

  enemy_scheduler dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .scene(scene), .level(level),
    .slot_free(slot_free), .spawn(spawn), .spawn_X(spawn_X), .spawned(spawned),
    .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given tick strobe; lane model predicts spawn_X for any spawn.
  task automatic step(input logic en);
    logic [1:0] el;
    logic [8:0] ex;
    clk_en = en;
    el = (m_lfsr[1:0] == m_last) ? m_lfsr[1:0] + 2'd1 : m_lfsr[1:0];
    ex = 9'(64 + int'(el) * 48);
    @(posedge clk);
    #1;
    if (rst) m_last = 2'd0;
    else if (spawned) begin
      pulses++;
      chk("lane_model", 32'(spawn_X), 32'(ex));
      m_last = el;
    end
    m_lfsr = rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    chk("onehot_pulse", 32'($onehot0(spawn) && (spawned == |spawn)), 32'd1);
    clk_en = 1'b0;
  endtask

  task automatic measure(input int gap, output int n, output logic [3:0] sp);
    bit done;
    done = 1'b0;
    n = 0;
    sp = '0;
    while (!done && n < 300) begin
      step(1'b1);
      n++;
      if (spawned) begin sp = spawn; done = 1'b1; end
      for (int i = 0; i < gap && !done; i++) begin
        step(1'b0);
        if (spawned) begin sp = spawn; done = 1'b1; end
      end
    end
  endtask

  initial begin
    int n;
    int p0;
    logic [3:0] sp;
    logic [8:0] prev_x;
    step(1'b0);
    step(1'b0);
    chk("rst_spawn", 32'(spawn), 32'd0);
    chk("rst_spawned", 32'(spawned), 32'd0);
    chk("rst_x", 32'(spawn_X), 32'd0);
    chk("rst_active", 32'(active_cnt), 32'd0);
    rst = 1'b0;
    scene = 2'd1;
    step(1'b0);
    measure(9, n, sp);
    chk("base_ticks1", n, 90);
    chk("base_slot1", 32'(sp), 32'b0001);
    step(1'b0);
    chk("pulse_drop", 32'(spawned), 32'd0);
    chk("spawn_drop", 32'(spawn), 32'd0);
    measure(9, n, sp);
    chk("base_ticks2", n, 90);
    chk("base_slot2", 32'(sp), 32'b0010);
    level = 5'd31;
    measure(1, n, sp);
    chk("floor_ticks", n, 20);
    level = 5'd10;
    measure(1, n, sp);
    chk("lvl10_ticks", n, 50);
    level = 5'd31;
    measure(1, n, sp);
    chk("lvl31_again", n, 20);
    slot_free = 4'b0000;
    p0 = pulses;
    repeat (20) step(1'b1);
    repeat (5) step(1'b0);
    chk("pend_nospawn", pulses, p0);
    slot_free = 4'b0100;
    step(1'b0);
    chk("pend_slot", 32'(spawn), 32'b0100);
    chk("pend_pulse", 32'(spawned), 32'd1);
    slot_free = 4'b1001;
    measure(1, n, sp);
    chk("rr_ticks", n, 20);
    chk("rr_slot3", 32'(sp), 32'b1000);
    measure(1, n, sp);
    chk("rr_slot0", 32'(sp), 32'b0001);
    slot_free = 4'hF;
    prev_x = spawn_X;
    for (int i = 0; i < 64; i++) begin
      measure(1, n, sp);
      chk("lane_set", 32'(spawn_X == 9'd64 || spawn_X == 9'd112 || spawn_X == 9'd160 || spawn_X == 9'd208), 32'd1);
      chk("lane_repeat", 32'(spawn_X != prev_x), 32'd1);
      prev_x = spawn_X;
    end
    slot_free = 4'b0000;
    p0 = pulses;
    repeat (20) step(1'b1);
    repeat (3) step(1'b0);
    scene = 2'd2;
    slot_free = 4'hF;
    step(1'b0);
    step(1'b0);
    chk("exit_nospawn", pulses, p0);
    scene = 2'd1;
    step(1'b0);
    measure(1, n, sp);
    chk("exit_restart", n, 20);
    repeat (10) step(1'b1);
    scene = 2'd0;
    step(1'b0);
    scene = 2'd1;
    step(1'b0);
    measure(1, n, sp);
    chk("midcount_restart", n, 20);
    slot_free = 4'b0101;
    p0 = pulses;
    repeat (20) step(1'b1);
    chk("pre_rst_nospawn", pulses, p0);
    chk("active_cnt2", 32'(active_cnt), 32'd2);
    rst = 1'b1;
    step(1'b0);
    chk("midrst_spawn", 32'(spawn), 32'd0);
    chk("midrst_pulse", 32'(spawned), 32'd0);
    chk("midrst_x", 32'(spawn_X), 32'd0);
    chk("midrst_active", 32'(active_cnt), 32'd0);
    rst = 1'b0;
    step(1'b0);
    chk("post_rst_active", 32'(active_cnt), 32'd2);
    slot_free = 4'b0001;
    chk("active_lag", 32'(active_cnt), 32'd2);
    step(1'b0);
    chk("active_upd", 32'(active_cnt), 32'd3);
    chk("post_rst_nospawn", pulses, p0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
